// File: rtl/half_adder_if.sv
// Operand/result bundle for the lane-parallel half adder.
// The master drives operands and controls; the slave returns registered results.
interface half_adder_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
);
    localparam int PC_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic             clr_total;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] C;
    logic             out_valid;
    logic [PC_W-1:0]  c_count;
    logic [CNT_W-1:0] carry_total;
    logic             total_sat;

    modport master (
        output A, B, in_valid, clr_total,
        input  S, C, out_valid, c_count, carry_total, total_sat
    );

    modport slave (
        input  A, B, in_valid, clr_total,
        output S, C, out_valid, c_count, carry_total, total_sat
    );
endinterface

// File: rtl/half_adder.sv
// Registered lane-parallel half adder with per-beat carry popcount and a
// saturating, sticky running carry total.
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    half_adder_if.slave  bus
);
    localparam int PC_W  = $clog2(WIDTH + 1);
    // The adder must hold the total plus a full-width popcount without wrapping.
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] TOT_MAX = SUM_W'({CNT_W{1'b1}});

    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [PC_W-1:0]  cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             sat_q, sat_d;

    logic [WIDTH-1:0] carry_w;
    logic [PC_W-1:0]  pop_w;
    logic [SUM_W-1:0] sum_w;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        valid_d = bus.in_valid;
        total_d = total_q;
        sat_d   = sat_q;

        carry_w = bus.A & bus.B;
        pop_w   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_w = pop_w + PC_W'(carry_w[i]);
        end
        sum_w = SUM_W'(total_q) + SUM_W'(pop_w);

        if (bus.in_valid) begin
            s_d   = bus.A ^ bus.B;
            c_d   = carry_w;
            cnt_d = pop_w;
            if (sum_w > TOT_MAX) begin
                total_d = '1;
                sat_d   = 1'b1;
            end else begin
                total_d = sum_w[CNT_W-1:0];
            end
        end

        // Clear wins over a simultaneous beat: its carries never reach the total.
        if (bus.clr_total) begin
            total_d = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            c_q     <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            total_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            total_q <= total_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.S           = s_q;
    assign bus.C           = c_q;
    assign bus.c_count     = cnt_q;
    assign bus.out_valid   = valid_q;
    assign bus.carry_total = total_q;
    assign bus.total_sat   = sat_q;
endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench for half_adder: a WIDTH=1/CNT_W=16 instance and a
// WIDTH=8/CNT_W=4 instance driven in lockstep from one stimulus process.
module tb_half_adder;
    localparam int MAX8 = 15;
    localparam int MAX1 = 65535;

    typedef struct {
        logic [7:0] s;
        logic [7:0] c;
        int         cnt;
        int         total;
        bit         sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    half_adder_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    half_adder_if #(.WIDTH(8), .CNT_W(4))  if8 ();

    half_adder #(.WIDTH(1), .CNT_W(16)) u_w1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    half_adder #(.WIDTH(8), .CNT_W(4))  u_w8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    always #5 clk = ~clk;

    exp_t q1[$];
    exp_t q8[$];
    exp_t last1, last8;
    int   tot1, tot8;
    bit   sat1, sat8;
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the total is a clamped integer sum; clear discards the beat's carries.
    task automatic model(input int pop, input bit v, input bit clr, input int maxv,
                         inout int tot, inout bit sat);
        if (clr) begin
            tot = 0;
            sat = 1'b0;
        end else if (v) begin
            if (tot + pop > maxv) begin
                tot = maxv;
                sat = 1'b1;
            end else begin
                tot = tot + pop;
            end
        end
    endtask

    task automatic step(input logic [7:0] a8, input logic [7:0] b8, input bit v8, input bit clr8,
                        input logic a1, input logic b1, input bit v1, input bit clr1);
        exp_t e;
        int   pop;
        @(negedge clk);
        if8.A = a8; if8.B = b8; if8.in_valid = v8; if8.clr_total = clr8;
        if1.A = a1; if1.B = b1; if1.in_valid = v1; if1.clr_total = clr1;
        pop = v8 ? $countones(a8 & b8) : 0;
        model(pop, v8, clr8, MAX8, tot8, sat8);
        if (v8) begin
            e.s = a8 ^ b8; e.c = a8 & b8; e.cnt = pop; e.total = tot8; e.sat = sat8;
            q8.push_back(e);
        end
        pop = v1 ? $countones(a1 & b1) : 0;
        model(pop, v1, clr1, MAX1, tot1, sat1);
        if (v1) begin
            e.s = {7'b0, a1 ^ b1}; e.c = {7'b0, a1 & b1}; e.cnt = pop; e.total = tot1; e.sat = sat1;
            q1.push_back(e);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_w8_S"},     if8.S, 0);
        check({tag, "_w8_C"},     if8.C, 0);
        check({tag, "_w8_cnt"},   if8.c_count, 0);
        check({tag, "_w8_valid"}, if8.out_valid, 0);
        check({tag, "_w8_total"}, if8.carry_total, 0);
        check({tag, "_w8_sat"},   if8.total_sat, 0);
        check({tag, "_w1_S"},     if1.S, 0);
        check({tag, "_w1_C"},     if1.C, 0);
        check({tag, "_w1_valid"}, if1.out_valid, 0);
        check({tag, "_w1_total"}, if1.carry_total, 0);
        check({tag, "_w1_sat"},   if1.total_sat, 0);
    endtask

    task automatic clear_model();
        q1.delete(); q8.delete();
        tot1 = 0; tot8 = 0; sat1 = 1'b0; sat8 = 1'b0;
        last1 = '{default: 0}; last8 = '{default: 0};
    endtask

    // Monitor: pops an expectation whenever a result is presented, else checks hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (if8.out_valid) begin
                if (q8.size() == 0) begin
                    check("w8_spurious_valid", if8.out_valid, 0);
                end else begin
                    e = q8.pop_front();
                    check("w8_S", if8.S, e.s);
                    check("w8_C", if8.C, e.c);
                    check("w8_cnt", if8.c_count, e.cnt);
                    check("w8_total", if8.carry_total, e.total);
                    check("w8_sat", if8.total_sat, e.sat);
                    last8 = e;
                end
            end else begin
                check("w8_hold_S", if8.S, last8.s);
                check("w8_hold_C", if8.C, last8.c);
                check("w8_hold_cnt", if8.c_count, last8.cnt);
            end
            if (if1.out_valid) begin
                if (q1.size() == 0) begin
                    check("w1_spurious_valid", if1.out_valid, 0);
                end else begin
                    e = q1.pop_front();
                    check("w1_S", if1.S, e.s[0]);
                    check("w1_C", if1.C, e.c[0]);
                    check("w1_cnt", if1.c_count, e.cnt);
                    check("w1_total", if1.carry_total, e.total);
                    check("w1_sat", if1.total_sat, e.sat);
                    last1 = e;
                end
            end else begin
                check("w1_hold_S", if1.S, last1.s[0]);
                check("w1_hold_C", if1.C, last1.c[0]);
            end
        end
    end

    initial begin
        clear_model();
        rst_n = 1'b0;
        if8.A = '0; if8.B = '0; if8.in_valid = 1'b0; if8.clr_total = 1'b0;
        if1.A = '0; if1.B = '0; if1.in_valid = 1'b0; if1.clr_total = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, back to back.
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 1, 0);
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b1, 1, 0);
        step(8'h00, 8'h00, 0, 0, 1'b1, 1'b0, 1, 0);
        step(8'h00, 8'h00, 0, 0, 1'b1, 1'b1, 1, 0);

        // WIDTH=8 pattern, then idle with all-ones and X operands.
        step(8'hF0, 8'hCC, 1, 0, 1'b0, 1'b0, 0, 0);
        step(8'hFF, 8'hFF, 0, 0, 1'b0, 1'b0, 0, 0);
        step('x,    'x,    0, 0, 1'bx, 1'bx, 0, 0);
        step(8'hFF, 8'hFF, 0, 0, 1'b1, 1'b1, 0, 0);
        @(negedge clk);
        check("pat_S", if8.S, 8'h3C);
        check("pat_C", if8.C, 8'hC0);
        check("pat_cnt", if8.c_count, 2);
        check("idle_valid", if8.out_valid, 0);
        check("idle_total8", if8.carry_total, 2);
        check("w1_total_end", if1.carry_total, 1);

        // Asynchronous reset mid-stream, with a beat held during reset.
        step(8'hFF, 8'hFF, 1, 0, 1'b1, 1'b1, 1, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        if8.in_valid = 1'b0; if1.in_valid = 1'b0;

        // Saturation on CNT_W=4, then clear together with a beat.
        step(8'hFF, 8'hFF, 1, 0, 1'b1, 1'b1, 1, 0);
        step(8'hFF, 8'hFF, 1, 0, 1'b0, 1'b0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        check("sat_total", if8.carry_total, 15);
        check("sat_flag", if8.total_sat, 1);
        check("post_rst_w1_C", if1.C, 1);
        check("post_rst_w1_total", if1.carry_total, 1);
        step(8'hFF, 8'hFF, 1, 1, 1'b0, 1'b0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 0);
        check("clr_S", if8.S, 8'h00);
        check("clr_C", if8.C, 8'hFF);
        check("clr_total", if8.carry_total, 0);
        check("clr_sat", if8.total_sat, 0);

        // Randomised traffic with sporadic clears.
        for (int i = 0; i < 400; i++) begin
            step(8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 0);
        step(8'h00, 8'h00, 0, 0, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        check("rand_total8", if8.carry_total, tot8);
        check("rand_sat8", if8.total_sat, sat8);
        check("rand_total1", if1.carry_total, tot1);
        check("w8_drained", q8.size(), 0);
        check("w1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
